// File: rtl/button_pkg.sv
// Shared types and default timing for the push-button input stage.
`timescale 1ns/1ps
package button_pkg;

  typedef logic bool;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    HELD            = 2'd2,
    RELEASE_PENDING = 2'd3
  } debounce_state_t;

  // 10 ms and 1 s at a 50 MHz clock
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT   = 500000;
  localparam int unsigned LONG_PRESS_CYCLES_DEFAULT = 50000000;

endpackage

// File: rtl/button_debouncer_channel.sv
// One button: 2-flop synchronizer, debounce FSM and counter, registered outputs.
// Long-press hold counter is built only when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
`timescale 1ns/1ps
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic button_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  debounce_state_t state;
  logic [CW-1:0]   cnt;
  bool             press_accept;
  bool             release_accept;

  // Sync flops idle at 1 so a reset never looks like a press.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= button_n;
      sync2 <= sync1;
    end
  end

  always_comb begin
    press_accept   = (state == PRESS_PENDING)   && !sync2 && (cnt == CNT_LAST);
    release_accept = (state == RELEASE_PENDING) &&  sync2 && (cnt == CNT_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RELEASED;
      cnt           <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        RELEASED: begin
          if (!sync2) begin
            state <= PRESS_PENDING;
            cnt   <= '0;
          end
        end
        PRESS_PENDING: begin
          if (sync2) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (press_accept) begin
            state       <= HELD;
            cnt         <= '0;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (sync2) begin
            state <= RELEASE_PENDING;
            cnt   <= '0;
          end
        end
        RELEASE_PENDING: begin
          if (!sync2) begin
            state <= HELD;
            cnt   <= '0;
          end else if (release_accept) begin
            state         <= RELEASED;
            cnt           <= '0;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_PRESS_CYCLES);

  logic [HW-1:0] hold_cnt;

  // Parking at HOLD_SAT (one past the firing value) blocks repeats until a new press.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (press_accept) begin
        hold_cnt <= '0;
      end else if (state == HELD || state == RELEASE_PENDING) begin
        if (hold_cnt < HOLD_LAST) begin
          hold_cnt <= hold_cnt + HW'(1);
        end else if (hold_cnt == HOLD_LAST) begin
          long_press <= 1'b1;
          hold_cnt   <= HOLD_SAT;
        end
      end
    end
  end
`else
  // Constant 0; the parameter is referenced only to keep the interface uniform.
  assign long_press = 1'b0 & (LONG_PRESS_CYCLES != 0);
`endif

endmodule

// File: rtl/button_debouncer.sv
// Debounced push-button input stage: one debounce_channel per button.
// Define BUTTON_DEBOUNCER_LONG_PRESS_EN to enable the long_press pulses.
`timescale 1ns/1ps
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS       = 3,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button_n,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] long_press
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_channel
    debounce_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_channel (
      .clock        (clock),
      .reset        (reset),
      .button_n     (button_n[i]),
      .pressed      (pressed[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i])
    );
  end

endmodule
